// File: rtl/tlut_mul_pkg.sv
// Shared definitions for the temporal-LUT multiplier sequencer.
//  - TLUT_A_WIDTH / TLUT_B_WIDTH : default operand widths
//  - tlut_seq_state_e            : sequencer FSM states (2-bit encoding)
package tlut_mul_pkg;

   localparam int TLUT_A_WIDTH = 4;
   localparam int TLUT_B_WIDTH = 8;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      RUN  = 2'd1,
      DONE = 2'd2
   } tlut_seq_state_e;

endpackage

// File: rtl/tlut_pulse_counter.sv
// Loadable down-counter that times the temporal pulse.
// Once loaded with a non-zero value it counts down by one per cycle and
// parks at zero, so it needs no separate enable.
//  clk      in  clock
//  rst      in  synchronous active-high reset (count -> 0)
//  load     in  load load_val on this edge
//  load_val in  WIDTH  value to load
//  cnt      out WIDTH  current count (cycles remaining incl. current one)
//  last     out count == 1
//  busy     out count != 0
module tlut_pulse_counter #(
   parameter int WIDTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             load,
   input  logic [WIDTH-1:0] load_val,
   output logic [WIDTH-1:0] cnt,
   output logic             last,
   output logic             busy
);

   localparam logic [WIDTH-1:0] CNT_ONE = WIDTH'(1);

   logic [WIDTH-1:0] cnt_q;
   logic [WIDTH-1:0] cnt_d;

   always_comb begin
      cnt_d = cnt_q;
      if (load) begin
         cnt_d = load_val;
      end else if (cnt_q != '0) begin
         cnt_d = cnt_q - CNT_ONE;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

   assign cnt  = cnt_q;
   assign last = (cnt_q == CNT_ONE);
   assign busy = (cnt_q != '0);

endmodule

// File: rtl/tlut_mul_seq.sv
// Temporal-LUT multiplier sequencer: accepts (a, b), runs a pulse of a
// cycles adding b once per cycle, and presents product = a*b.
//  clk, rst             clock, synchronous active-high reset
//  in_valid / in_ready  operand handshake (a_in, b_in)
//  pulse_en, pulse_cnt  temporal pulse active / cycles remaining
//  out_valid / out_ready result handshake (product)
module tlut_mul_seq
   import tlut_mul_pkg::*;
#(
   parameter int A_WIDTH = TLUT_A_WIDTH,
   parameter int B_WIDTH = TLUT_B_WIDTH,
   parameter int P_WIDTH = A_WIDTH + B_WIDTH
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [A_WIDTH-1:0] a_in,
   input  logic [B_WIDTH-1:0] b_in,
   output logic               pulse_en,
   output logic [A_WIDTH-1:0] pulse_cnt,
   output logic               out_valid,
   input  logic               out_ready,
   output logic [P_WIDTH-1:0] product
);

   tlut_seq_state_e    state_q, state_d;
   logic [B_WIDTH-1:0] b_q, b_d;
   logic [P_WIDTH-1:0] acc_q, acc_d;
   logic [P_WIDTH-1:0] prod_q, prod_d;
   logic [P_WIDTH-1:0] acc_sum;

   logic               cnt_load;
   logic [A_WIDTH-1:0] cnt;
   logic               cnt_last;
   logic               cnt_busy;
   logic               accept;

   tlut_pulse_counter #(
      .WIDTH (A_WIDTH)
   ) u_pulse_counter (
      .clk      (clk),
      .rst      (rst),
      .load     (cnt_load),
      .load_val (a_in),
      .cnt      (cnt),
      .last     (cnt_last),
      .busy     (cnt_busy)
   );

   assign acc_sum = acc_q + P_WIDTH'(b_q);

   always_comb begin
      state_d   = state_q;
      b_d       = b_q;
      acc_d     = acc_q;
      prod_d    = prod_q;
      cnt_load  = 1'b0;
      in_ready  = 1'b0;
      out_valid = 1'b0;
      pulse_en  = 1'b0;

      case (state_q)
         IDLE: begin
            in_ready = 1'b1;
         end
         RUN: begin
            pulse_en = cnt_busy;
            acc_d    = acc_sum;
            if (cnt_last) begin
               prod_d  = acc_sum;
               state_d = DONE;
            end
         end
         DONE: begin
            out_valid = 1'b1;
            // Ready for a new pair exactly when the result leaves, so a
            // result handshake and an operand accept can share one edge.
            in_ready  = out_ready;
            if (out_ready) begin
               state_d = IDLE;
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase

      accept = in_valid && in_ready;
      if (accept) begin
         b_d   = b_in;
         acc_d = '0;
         if (a_in != '0) begin
            cnt_load = 1'b1;
            state_d  = RUN;
         end else begin
            prod_d  = '0;
            state_d = DONE;
         end
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         b_q     <= '0;
         acc_q   <= '0;
         prod_q  <= '0;
      end else begin
         state_q <= state_d;
         b_q     <= b_d;
         acc_q   <= acc_d;
         prod_q  <= prod_d;
      end
   end

   assign pulse_cnt = cnt;
   assign product   = prod_q;

endmodule

// File: tb/tb_tlut_mul_seq.sv
module tb_tlut_mul_seq;

   logic        clk;
   logic        rst;
   logic        in_valid;
   logic        in_ready;
   logic [3:0]  a_in;
   logic [7:0]  b_in;
   logic        pulse_en;
   logic [3:0]  pulse_cnt;
   logic        out_valid;
   logic        out_ready;
   logic [11:0] product;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      int a;
      int b;
      int exp_p;
   } vec_t;

   vec_t vecs[6];

   tlut_mul_seq dut (
      .clk       (clk),
      .rst       (rst),
      .in_valid  (in_valid),
      .in_ready  (in_ready),
      .a_in      (a_in),
      .b_in      (b_in),
      .pulse_en  (pulse_en),
      .pulse_cnt (pulse_cnt),
      .out_valid (out_valid),
      .out_ready (out_ready),
      .product   (product)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d", name, act, exp);
      end
   endtask

   // Wait (bounded) for out_valid; cyc counts cycles after the accept edge.
   task automatic wait_result(input int a, input string tag, output int cyc, output int pulses);
      cyc = 1;
      pulses = 0;
      while (!out_valid && cyc <= 40) begin
         if (pulse_en) begin
            check({tag, "_pulse_cnt"}, 32'(pulse_cnt), 32'(a - pulses));
            pulses++;
         end
         step();
         cyc++;
      end
   endtask

   task automatic run_vec(input int a, input int b, input int exp_p, input string tag);
      int cyc;
      int pulses;
      a_in = a[3:0];
      b_in = b[7:0];
      in_valid = 1'b1;
      check({tag, "_in_ready"}, 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      wait_result(a, tag, cyc, pulses);
      check({tag, "_latency"}, 32'(cyc), 32'(a + 1));
      check({tag, "_pulses"}, 32'(pulses), 32'(a));
      check({tag, "_product"}, 32'(product), 32'(exp_p));
      $display("txn %s: a=%0d b=%0d product=%0d latency=%0d pulses=%0d",
               tag, a, b, product, cyc, pulses);
      if (out_ready) begin
         step();
         check({tag, "_released"}, 32'(out_valid), 32'd0);
      end
   endtask

   initial begin
      int cyc;
      int pulses;
      int stale;

      vecs[0] = '{a: 3,  b: 5,   exp_p: 15};
      vecs[1] = '{a: 0,  b: 200, exp_p: 0};
      vecs[2] = '{a: 15, b: 255, exp_p: 3825};
      vecs[3] = '{a: 1,  b: 1,   exp_p: 1};
      vecs[4] = '{a: 7,  b: 9,   exp_p: 63};
      vecs[5] = '{a: 5,  b: 0,   exp_p: 0};

      rst = 1'b1;
      in_valid = 1'b0;
      a_in = '0;
      b_in = '0;
      out_ready = 1'b1;
      step();
      step();
      rst = 1'b0;
      check("rst_in_ready", 32'(in_ready), 32'd1);
      check("rst_out_valid", 32'(out_valid), 32'd0);
      check("rst_pulse_en", 32'(pulse_en), 32'd0);
      check("rst_pulse_cnt", 32'(pulse_cnt), 32'd0);
      check("rst_product", 32'(product), 32'd0);
      $display("txn reset: in_ready=%0d out_valid=%0d product=%0d", in_ready, out_valid, product);

      for (int i = 0; i < 6; i++) begin
         run_vec(vecs[i].a, vecs[i].b, vecs[i].exp_p, $sformatf("vec%0d", i));
      end

      // Backpressure: result held for 5 cycles with out_ready low.
      out_ready = 1'b0;
      a_in = 4'd2;
      b_in = 8'd7;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_result(2, "bp", cyc, pulses);
      check("bp_latency", 32'(cyc), 32'd3);
      for (int k = 0; k < 5; k++) begin
         check("bp_out_valid", 32'(out_valid), 32'd1);
         check("bp_product", 32'(product), 32'd14);
         check("bp_in_ready", 32'(in_ready), 32'd0);
         step();
      end
      out_ready = 1'b1;
      #1;
      check("bp_in_ready_rel", 32'(in_ready), 32'd1);
      check("bp_product_rel", 32'(product), 32'd14);
      step();
      check("bp_released", 32'(out_valid), 32'd0);
      $display("txn backpressure: a=2 b=7 product=14 held 5 cycles");

      // Back-to-back: second pair accepted on the result handshake edge.
      a_in = 4'd4;
      b_in = 8'd3;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      wait_result(4, "b2b0", cyc, pulses);
      check("b2b0_latency", 32'(cyc), 32'd5);
      check("b2b0_product", 32'(product), 32'd12);
      a_in = 4'd1;
      b_in = 8'd9;
      in_valid = 1'b1;
      #1;
      check("b2b_in_ready", 32'(in_ready), 32'd1);
      step();
      in_valid = 1'b0;
      check("b2b_no_bubble_pulse", 32'(pulse_en), 32'd1);
      check("b2b_pulse_cnt", 32'(pulse_cnt), 32'd1);
      check("b2b_out_valid_low", 32'(out_valid), 32'd0);
      step();
      check("b2b1_out_valid", 32'(out_valid), 32'd1);
      check("b2b1_product", 32'(product), 32'd9);
      step();
      check("b2b1_released", 32'(out_valid), 32'd0);
      $display("txn back-to-back: products 12 then 9");

      // Reset mid-RUN discards the in-flight result.
      a_in = 4'd10;
      b_in = 8'd6;
      in_valid = 1'b1;
      step();
      in_valid = 1'b0;
      step();
      step();
      step();
      rst = 1'b1;
      step();
      rst = 1'b0;
      check("mrst_pulse_en", 32'(pulse_en), 32'd0);
      check("mrst_pulse_cnt", 32'(pulse_cnt), 32'd0);
      check("mrst_out_valid", 32'(out_valid), 32'd0);
      check("mrst_in_ready", 32'(in_ready), 32'd1);
      check("mrst_product", 32'(product), 32'd0);
      stale = 0;
      for (int k = 0; k < 15; k++) begin
         if (out_valid) stale++;
         step();
      end
      check("mrst_no_stale", 32'(stale), 32'd0);
      $display("txn reset-mid-run: stale out_valid cycles=%0d", stale);
      run_vec(2, 2, 4, "post_rst");

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
